// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI transaction arbiter and its round-robin picker.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        BUSY    = 3'd2,
        RESP    = 3'd3,
        RECOVER = 3'd4
    } arb_state_t;

    localparam int SPI_DW         = 16;
    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_GAP_CYCLES = 8;

    // Index width for n clients; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Client-side request/response bus plus the SPI master start/done handshake.
interface spi_txn_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = SPI_DW
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] cmd;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rsp_vld;
    logic [DW-1:0]         rsp_data;
    logic                  busy;
    logic                  spi_wrt;
    logic [DW-1:0]         spi_cmd;
    logic                  spi_done;
    logic [DW-1:0]         spi_resp;

    modport slave (
        input  req, cmd, spi_done, spi_resp,
        output gnt, rsp_vld, rsp_data, busy, spi_wrt, spi_cmd
    );

    modport master (
        output req, cmd, spi_done, spi_resp,
        input  gnt, rsp_vld, rsp_data, busy, spi_wrt, spi_cmd
    );
endinterface

// File: rtl/spi_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] win_o,
    output logic          any_o
);
    always_comb begin
        int idx;
        win_o = '0;
        any_o = |req_i;
        idx   = 0;
        // Walk from the farthest offset down so the nearest requester after ptr_i wins.
        for (int off = N; off >= 1; off--) begin
            idx = int'(ptr_i) + off;
            if (idx >= N) idx = idx - N;
            if (req_i[PW'(idx)]) win_o = PW'(idx);
        end
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among NUM_REQ clients with round-robin grants and done-edge completion.
// Define SPI_GAP_EN to stretch RECOVER to GAP_CYCLES cycles for the slave's SS_n-high time.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DW         = SPI_DW,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_txn_arbiter_if.slave arb_if
);
    localparam int PW = ptr_w(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]      spi_cmd_q, spi_cmd_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic               done_q;
    logic               done_rise;
    logic               gap_done;
    logic               pick_any;
    logic [PW-1:0]      pick_win;
    logic [DW-1:0]      cmd_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
        assign cmd_arr[gi] = arb_if.cmd[gi*DW +: DW];
    end

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req_i (arb_if.req),
        .ptr_i (rr_ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    // A done level left high by the previous transfer is not a completion.
    assign done_rise = arb_if.spi_done & ~done_q;

`ifdef SPI_GAP_EN
    localparam int CW = $clog2(GAP_CYCLES + 1);
    logic [CW-1:0] gap_q, gap_d;

    always_comb begin
        gap_d = gap_q;
        if (state_q == RESP)
            gap_d = CW'(GAP_CYCLES - 1);
        else if (state_q == RECOVER && gap_q != '0)
            gap_d = gap_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gap_q <= '0;
        else        gap_q <= gap_d;
    end

    assign gap_done = (gap_q == '0);
`else
    assign gap_done = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        spi_cmd_d  = spi_cmd_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d     = NUM_REQ'(1) << pick_win;
                    spi_cmd_d = cmd_arr[pick_win];
                    rr_ptr_d  = pick_win;
                    state_d   = ISSUE;
                end
            end
            ISSUE:   state_d = BUSY;
            BUSY: begin
                if (done_rise) begin
                    rsp_data_d = arb_if.spi_resp;
                    state_d    = RESP;
                end
            end
            RESP: begin
                gnt_d   = '0;
                state_d = RECOVER;
            end
            RECOVER: if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= PW'(NUM_REQ - 1);
            spi_cmd_q  <= '0;
            rsp_data_q <= '0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            spi_cmd_q  <= spi_cmd_d;
            rsp_data_q <= rsp_data_d;
            done_q     <= arb_if.spi_done;
        end
    end

    assign arb_if.gnt      = gnt_q;
    assign arb_if.rsp_vld  = (state_q == RESP) ? gnt_q : '0;
    assign arb_if.rsp_data = rsp_data_q;
    assign arb_if.busy     = (state_q != IDLE);
    assign arb_if.spi_wrt  = (state_q == ISSUE);
    assign arb_if.spi_cmd  = spi_cmd_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed plus randomized bench for spi_txn_arbiter; the bench plays both the clients and the SPI master.
module tb_spi_txn_arbiter;
    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int GAP = 8;
`ifdef SPI_GAP_EN
    localparam int SPACING = GAP + 2;
`else
    localparam int SPACING = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_txn_arbiter_if #(.NUM_REQ(N), .DW(DW)) arb_if ();

    spi_txn_arbiter #(.NUM_REQ(N), .DW(DW), .GAP_CYCLES(GAP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (arb_if.slave)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_txn = 0;
    int            last_win = N - 1;
    int            rsp_cyc = 0;
    bit            have_prev = 0;
    bit            spacing_valid = 0;
    logic [N-1:0]  req_v = '0;
    logic [DW-1:0] cmd_word [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester after the last winner, modulo N.
    function automatic int model_win(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) arb_if.cmd[i*DW +: DW] = cmd_word[i];
    endtask

    // Clients get a fresh command word only when their request rises.
    task automatic set_req(input logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[i] && !req_v[i]) cmd_word[i] = DW'($urandom);
        req_v = r;
        arb_if.req = r;
        pack();
    endtask

    task automatic txn(input int dly, input int stale, input logic [DW-1:0] resp,
                       input bit drop_win, input bit clear_all, input logic [N-1:0] add_req,
                       output int won);
        int w;
        int start;
        int n;
        int spur;
        bit from_idle;
        logic [N-1:0] wbit;
        from_idle = (arb_if.busy === 1'b0);
        w = model_win(req_v, last_win);
        won = w;
        wbit = N'(1) << w;
        start = cyc;
        n = 0;
        while (arb_if.spi_wrt !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("wrt_seen", 32'(arb_if.spi_wrt), 1);
        if (from_idle) check("issue_latency", cyc - start, 1);
        if (have_prev && spacing_valid) check("rsp_to_wrt_spacing", cyc - rsp_cyc, SPACING);
        check("gnt_issue", 32'(arb_if.gnt), 32'(wbit));
        check("spi_cmd", 32'(arb_if.spi_cmd), 32'(cmd_word[w]));
        check("busy_issue", 32'(arb_if.busy), 1);
        last_win = w;
        tick();
        check("wrt_single_pulse", 32'(arb_if.spi_wrt), 0);
        spur = 0;
        repeat (stale) begin
            spur += (arb_if.rsp_vld != 0) ? 1 : 0;
            tick();
        end
        arb_if.spi_done = 1'b0;
        if (drop_win) set_req(req_v & ~wbit);
        repeat (dly) begin
            tick();
            spur += (arb_if.rsp_vld != 0) ? 1 : 0;
        end
        check("no_early_rsp", spur, 0);
        check("gnt_held_busy", 32'(arb_if.gnt), 32'(wbit));
        arb_if.spi_resp = resp;
        arb_if.spi_done = 1'b1;
        tick();
        check("rsp_vld", 32'(arb_if.rsp_vld), 32'(wbit));
        check("rsp_data", 32'(arb_if.rsp_data), 32'(resp));
        rsp_cyc = cyc;
        have_prev = 1;
        if (clear_all) set_req(add_req);
        else           set_req((req_v & ~wbit) | add_req);
        spacing_valid = (req_v != 0);
        $display("txn %0d: client %0d cmd %h resp %h", n_txn, w, cmd_word[w], resp);
        n_txn++;
        tick();
        check("gnt_recover", 32'(arb_if.gnt), 0);
        check("rsp_vld_one_cycle", 32'(arb_if.rsp_vld), 0);
    endtask

    initial begin
        int won;
        int cnt;
        for (int i = 0; i < N; i++) cmd_word[i] = '0;
        arb_if.req = '0;
        arb_if.cmd = '0;
        arb_if.spi_done = 1'b1;
        arb_if.spi_resp = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(arb_if.gnt), 0);
        check("rst_rsp_vld", 32'(arb_if.rsp_vld), 0);
        check("rst_rsp_data", 32'(arb_if.rsp_data), 0);
        check("rst_busy", 32'(arb_if.busy), 0);
        check("rst_spi_wrt", 32'(arb_if.spi_wrt), 0);
        check("rst_spi_cmd", 32'(arb_if.spi_cmd), 0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req_busy", 32'(arb_if.busy), 0);

        // All clients requesting: strict 0,1,2 rotation.
        set_req(3'b111);
        for (int t = 0; t < 6; t++) begin
            txn($urandom_range(1, 5), 0, DW'($urandom), 0, t == 5, (t == 5) ? 3'b000 : 3'b111, won);
            check("rr_order", won, t % 3);
        end
        repeat (3) tick();

        // Single request with fixed words.
        set_req(3'b010);
        cmd_word[1] = 16'hA5C3;
        pack();
        txn(3, 0, 16'h1234, 0, 1, 3'b000, won);
        check("single_client", won, 1);
        repeat (3) tick();

        // Done held high into BUSY before it drops and rises again.
        set_req(3'b100);
        txn(2, 2, 16'hBEEF, 0, 1, 3'b000, won);
        repeat (3) tick();

        // Client 0 withdraws mid-transfer; the arbiter must finish and then idle.
        set_req(3'b001);
        txn(3, 0, 16'h0F0F, 1, 1, 3'b000, won);
        cnt = 0;
        repeat (GAP + 4) begin
            tick();
            cnt += arb_if.spi_wrt ? 1 : 0;
        end
        check("drop_idle_busy", 32'(arb_if.busy), 0);
        check("drop_no_wrt", cnt, 0);

        // Reset in the middle of BUSY.
        set_req(3'b011);
        cnt = 0;
        while (arb_if.spi_wrt !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
        end
        check("rst_test_wrt_seen", 32'(arb_if.spi_wrt), 1);
        tick();
        arb_if.spi_done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(arb_if.gnt), 0);
        check("midrst_rsp_vld", 32'(arb_if.rsp_vld), 0);
        check("midrst_rsp_data", 32'(arb_if.rsp_data), 0);
        check("midrst_busy", 32'(arb_if.busy), 0);
        check("midrst_spi_wrt", 32'(arb_if.spi_wrt), 0);
        check("midrst_spi_cmd", 32'(arb_if.spi_cmd), 0);
        arb_if.spi_done = 1'b1;
        set_req(3'b000);
        repeat (2) tick();
        rst_n = 1'b1;
        last_win = N - 1;
        have_prev = 0;
        spacing_valid = 0;
        tick();
        set_req(3'b100);
        txn(2, 0, DW'($urandom), 0, 0, 3'b001, won);
        check("post_rst_grant", won, 2);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 30; t++) begin
            if (req_v == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                set_req(N'($urandom_range(1, 7)));
            end
            txn($urandom_range(1, 6), $urandom_range(0, 2), DW'($urandom),
                $urandom_range(0, 3) == 0, 0, N'($urandom_range(0, 7)), won);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
